mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port synchronous data/instruction RAM between the processor (port 0) and a second bus master such as a program loader or debug/DMA engine (port 1). It issues at most one memory access per cycle. Port 0 has fixed priority, and a starvation counter bounds how long port 1 can wait. Read data returns one cycle after issue, tagged to the issuing port.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- STARVE_LIMIT, 4: consecutive denied cycles after which port 1 wins over port 0. Legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DW  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data, valid one cycle after the address is presented.

## Operation
Grant decision is combinational within the cycle:
- sel1 = req1 & (~req0 | starve_cnt == STARVE_LIMIT).
- gnt1 = sel1.
- gnt0 = req0 & ~sel1.
- While resetn = 0, gnt0 = gnt1 = 0 regardless of requests.

Memory mux:
- mem_addr, mem_wdata and mem_we come from the granted port.
- mem_we = we_k & gnt_k for the granted port k; mem_we = 0 when there is no grant.
- With no grant, mem_addr and mem_wdata follow port 0. Their value is don't-care, but it must be stable and not X.

Requester rule:
- Once a port asserts req_k, it holds req_k, we_k, addr_k and wdata_k stable until the cycle in which gnt_k = 1.
- The handshake completes in that cycle.
- The port may present a new request in the following cycle, or keep req_k high to issue back-to-back.

Read return:
- Registered tag pend[1:0] = {gnt1 & ~we1, gnt0 & ~we0}, captured every cycle.
- rvalid_k = pend[k].
- rdata0 = rdata1 = mem_rdata (passthrough). The value is meaningful only when the matching rvalid is 1.

Writes:
- Complete in the grant cycle.
- No rvalid is produced.

Starvation counter (starve_cnt, 8-bit):
- Increments when req1 = 1 and gnt1 = 0.
- Clears to 0 when gnt1 = 1 or req1 = 0.
- Saturates at STARVE_LIMIT and never exceeds it.

State summary: pend[1:0] and starve_cnt are the only state. There is no other FSM.

## Timing
Reset values (synchronous, resetn = 0 at a rising edge):
- pend = 00, so rvalid0 = rvalid1 = 0.
- starve_cnt = 0.
- gnt0 = gnt1 = 0 and mem_we = 0 throughout any cycle with resetn low.

Latency:
- Grant: 0 cycles from req when uncontended.
- Read data: rvalid_k asserts exactly 1 cycle after gnt_k for a read.

Throughput:
- One access per cycle, including alternating ports.
- A port may have a read return (rvalid) and a new grant in the same cycle.

Boundary conditions:
- Both ports request, starve_cnt < STARVE_LIMIT: port 0 granted, starve_cnt increments.
- Both ports request, starve_cnt == STARVE_LIMIT: port 1 granted, starve_cnt clears.
  - Net effect under continuous contention: port 1 receives one grant every STARVE_LIMIT+1 cycles.
- req1 deasserts while starving: counter clears, and no grant credit is kept.
- Reset mid-read: if reset is asserted in the cycle after a read grant, rvalid is forced 0 in that cycle. The pending read is dropped.
- Read and write to the same address in consecutive cycles: the RAM's native behaviour applies. The arbiter adds no forwarding.

## Test plan
- Reset: hold resetn = 0 for 2 cycles with req0 = req1 = 1.
  - Expect gnt0 = gnt1 = 0, mem_we = 0, rvalid0 = rvalid1 = 0.
  - In the first cycle after release, expect gnt0 = 1.
- Single port 0 read at 0x10, RAM holds 0xDEADBEEF.
  - Expect gnt0 = 1 in cycle N and mem_addr = 0x10.
  - Expect rvalid0 = 1 and rdata0 = 0xDEADBEEF in cycle N+1.
  - Expect rvalid1 = 0 throughout.
- Port 1 write of 0x12345678 to 0x20 while port 0 is idle.
  - Expect gnt1 = 1, mem_we = 1, mem_addr = 0x20, mem_wdata = 0x12345678, with no rvalid.
  - Then a port 0 read of 0x20 returns 0x12345678.
- Continuous contention of reads with STARVE_LIMIT = 4 for 15 cycles.
  - Expect the grant pattern 0,0,0,0,1 repeated 3 times.
  - Expect each rvalid to follow its grant by exactly 1 cycle with the correct port tag.
- Starvation clear: req1 is denied for 2 cycles, deasserts for 1 cycle, then reasserts with req0 held high.
  - Expect port 1 to wait a full 4 more denied cycles before its grant.
- Reset mid-read: grant a port 1 read in cycle N and assert resetn = 0 in cycle N+1.
  - Expect rvalid1 = 0 in cycle N+1 and starve_cnt = 0 after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the single-port RAM side.
// The arbiter takes the slave modport; requesters and the RAM take the master side.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port fixed-priority RAM arbiter: port 0 wins unless port 1 has been denied
// STARVE_LIMIT consecutive cycles. Read data returns one cycle after grant, tagged by port.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           resetn,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic          gnt0, gnt1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;

  always_comb begin
    // Grants are gated by reset so nothing reaches the RAM while resetn is low.
    gnt1 = resetn & bus.req1 & (~bus.req0 | (starve_cnt_q == Limit));
    gnt0 = resetn & bus.req0 & ~gnt1;

    mem_addr  = bus.addr0;
    mem_wdata = bus.wdata0;
    mem_we    = gnt0 & bus.we0;
    if (gnt1) begin
      mem_addr  = bus.addr1;
      mem_wdata = bus.wdata1;
      mem_we    = bus.we1;
    end

    pend_d = {gnt1 & ~bus.we1, gnt0 & ~bus.we0};

    starve_cnt_d = 8'd0;
    if (bus.req1 && !gnt1) begin
      starve_cnt_d = (starve_cnt_q == Limit) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q       <= 2'b00;
      starve_cnt_q <= 8'd0;
    end else begin
      pend_q       <= pend_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  // A read pending across a reset assertion is dropped in that same cycle.
  assign bus.rvalid0   = pend_q[0] & resetn;
  assign bus.rvalid1   = pend_q[1] & resetn;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;

endmodule
